capture_uart_dump: RTL

- Downstream readout stage for the logic-analyzer capture buffer.
- On a dump request it walks the dual-port capture RAM read port from address 0 to DEPTH-1 and serialises every sample byte over a UART 8N1 line.
- Each frame carries a header byte and a trailing checksum so a PC host can resynchronise and validate the capture.
- Sits between the capture RAM read port and the board UART TX pin; the RAM read clock is driven from this block's clk.

---
 rtl/capture_uart_dump_if.sv | 39 +++
 rtl/capture_uart_dump.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/capture_uart_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : capture_uart_dump_if
// Description : Handshake bundle between the capture RAM read port, the
//               dump requester and the UART readout stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface capture_uart_dump_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  // Requester / RAM side
  modport master (
    output start,
    output rd_data,
    input  rd_addr,
    input  tx,
    input  busy,
    input  done
  );

  // Readout stage side
  modport slave (
    input  start,
    input  rd_data,
    output rd_addr,
    output tx,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/capture_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : capture_uart_dump
// Description : Walks the capture RAM from address 0 to DEPTH-1 and sends
//               HEADER, every sample byte and an 8-bit additive checksum
//               over a UART 8N1 line.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_uart_dump #(
  parameter int         ADDR_W   = 10,
  parameter int         DATA_W   = 8,          // must stay 8
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,              // asynchronous, active low
  capture_uart_dump_if.slave bus
);

  localparam int                BIT_CYC   = CLK_FREQ / BAUD;
  localparam int                CNT_W     = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [3:0]        STOP_IDX  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_CKSUM = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [3:0]        bit_idx_q;   // 0 start, 1..8 data, 9 stop
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] cksum_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              armed_q;     // blocks a start seen on the reset-release edge
  logic              tx_bit_d;

  // Line level for the bit that follows the current one (data bit or stop bit)
  always_comb begin
    tx_bit_d = 1'b1;
    if (bit_idx_q < 4'd8) begin
      tx_bit_d = shift_q[bit_idx_q[2:0]];
    end
  end

  // Dump sequencer: header, FETCH/LOAD/SEND per sample, checksum, done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      cksum_q   <= '0;
      rd_addr_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && armed_q) begin
            state_q   <= S_HDR;
            busy_q    <= 1'b1;
            cksum_q   <= '0;
            rd_addr_q <= '0;
            shift_q   <= HEADER;
            tx_q      <= 1'b0;
            bit_idx_q <= '0;
            baud_q    <= '0;
          end
        end
        // rd_addr was presented on entry; the RAM needs this cycle
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          shift_q   <= bus.rd_data;
          cksum_q   <= cksum_q + bus.rd_data;
          tx_q      <= 1'b0;
          bit_idx_q <= '0;
          baud_q    <= '0;
          state_q   <= S_SEND;
        end
        S_HDR, S_SEND, S_CKSUM: begin
          if (baud_q != BIT_LAST) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bit_idx_q != STOP_IDX) begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= tx_bit_d;
            end else begin
              bit_idx_q <= '0;
              case (state_q)
                S_HDR: begin
                  state_q <= S_FETCH;
                end
                S_SEND: begin
                  if (rd_addr_q == ADDR_LAST) begin
                    // Checksum follows immediately, no fetch gap
                    state_q <= S_CKSUM;
                    shift_q <= cksum_q;
                    tx_q    <= 1'b0;
                  end else begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    state_q   <= S_FETCH;
                  end
                end
                default: begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
`default_nettype wire
